// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic array datapath.
// Elements are signed Q8.8; the input skew block uses the state enum below.
package tpu_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;

    typedef logic signed [DATA_W-1:0] fixed_t;

    typedef enum logic [1:0] {
        SKEW_IDLE,
        SKEW_STREAM,
        SKEW_DRAIN
    } skew_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register of {valid, data} for one array row.
// Data is forced to zero whenever valid is low, so bubbles reach the PE as zeros.
module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [DEPTH-1:0]             r_vld;
    logic [DEPTH-1:0][DATA_W-1:0] r_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_dat <= '0;
        end else begin
            r_vld[0] <= i_valid;
            r_dat[0] <= i_valid ? i_data : '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_dat[k] <= r_dat[k-1];
            end
        end
    end

    assign o_valid = r_vld[DEPTH-1];
    assign o_data  = r_dat[DEPTH-1];

endmodule

// File: rtl/systolic_input_skew.sv
// Left-edge feeder for the PE array: row i sees each accepted vector i+1 cycles later,
// forming a diagonal wavefront. Tracks tile end so done pulses as the last element leaves row N-1.
module systolic_input_skew
    import tpu_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = tpu_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                skew_valid_in,
    output logic                skew_ready_out,
    input  logic [N*DATA_W-1:0] skew_data_in,
    input  logic                skew_last_in,
    input  logic                skew_switch_in,
    output logic [N*DATA_W-1:0] skew_data_out,
    output logic [N-1:0]        skew_valid_out,
    output logic                skew_switch_out,
    output logic                skew_busy_out,
    output logic                skew_done_out
);

    localparam int             CW       = $clog2(N) + 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(N - 1);

    skew_state_t   r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_ready, r_busy, r_done, r_switch;
    logic          w_accept;

    assign w_accept = skew_valid_in & r_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            SKEW_IDLE, SKEW_STREAM: begin
                if (w_accept)
                    w_state_nxt = skew_last_in ? SKEW_DRAIN : SKEW_STREAM;
            end
            SKEW_DRAIN: begin
                if (r_cnt == LAST_CNT) w_state_nxt = SKEW_IDLE;
                else                   w_cnt_nxt   = r_cnt + CW'(1);
            end
            default: w_state_nxt = SKEW_IDLE;
        endcase
    end

    // Status outputs are registered from the next-state decode so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= SKEW_IDLE;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_switch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ready  <= (w_state_nxt != SKEW_DRAIN);
            r_busy   <= (w_state_nxt != SKEW_IDLE);
            r_done   <= (w_state_nxt == SKEW_DRAIN) && (w_cnt_nxt == LAST_CNT);
            r_switch <= skew_switch_in & w_accept;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        skew_delay_line #(
            .DEPTH  (gi + 1),
            .DATA_W (DATA_W)
        ) u_dl (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_accept),
            .i_data  (skew_data_in[gi*DATA_W +: DATA_W]),
            .o_valid (skew_valid_out[gi]),
            .o_data  (skew_data_out[gi*DATA_W +: DATA_W])
        );
    end

    assign skew_ready_out  = r_ready;
    assign skew_busy_out   = r_busy;
    assign skew_done_out   = r_done;
    assign skew_switch_out = r_switch;

endmodule

// File: tb/tb_systolic_input_skew.sv
// Bench for systolic_input_skew (N=4): per-cycle control table plus a lane scoreboard
// that expects each accepted element on lane i exactly i+1 cycles after acceptance.
module tb_systolic_input_skew;

    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid_in = 1'b0;
    logic            last_in = 1'b0;
    logic            switch_in = 1'b0;
    logic [N*DW-1:0] data_in = '0;
    logic            ready_out, switch_out, busy_out, done_out;
    logic [N*DW-1:0] data_out;
    logic [N-1:0]    valid_out;

    always #5 clk = ~clk;

    systolic_input_skew #(.N(N), .DATA_W(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .skew_valid_in   (valid_in),
        .skew_ready_out  (ready_out),
        .skew_data_in    (data_in),
        .skew_last_in    (last_in),
        .skew_switch_in  (switch_in),
        .skew_data_out   (data_out),
        .skew_valid_out  (valid_out),
        .skew_switch_out (switch_out),
        .skew_busy_out   (busy_out),
        .skew_done_out   (done_out)
    );

    typedef struct {
        int          due;
        int          lane;
        logic [DW-1:0] d;
    } sb_t;

    typedef struct {
        logic            vld;
        logic [N*DW-1:0] d;
        logic            last;
        logic            sw;
        logic            e_rdy;
        logic            e_busy;
        logic            e_done;
        logic            e_sw;
    } row_t;

    sb_t  sb[$];
    row_t tbl[20];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    function automatic row_t mk(input logic vld, input logic [N*DW-1:0] d, input logic last,
                                input logic sw, input logic e_rdy, input logic e_busy,
                                input logic e_done, input logic e_sw);
        row_t r;
        r.vld = vld; r.d = d; r.last = last; r.sw = sw;
        r.e_rdy = e_rdy; r.e_busy = e_busy; r.e_done = e_done; r.e_sw = e_sw;
        return r;
    endfunction

    // Called just after a posedge: drive inputs, check this cycle's outputs at negedge,
    // record expected lane outputs for an accept, then advance to the next cycle.
    task automatic step(input logic vld, input logic [N*DW-1:0] d, input logic last,
                        input logic sw, input logic rs, input logic e_rdy, input logic e_busy,
                        input logic e_done, input logic e_sw);
        logic [N-1:0]    ev;
        logic [N*DW-1:0] ed;
        valid_in  = vld;
        data_in   = d;
        last_in   = last;
        switch_in = sw;
        rst       = rs;
        @(negedge clk);
        chk("ready", 64'(ready_out), 64'(e_rdy));
        chk("busy", 64'(busy_out), 64'(e_busy));
        chk("done", 64'(done_out), 64'(e_done));
        chk("switch", 64'(switch_out), 64'(e_sw));
        ev = '0;
        ed = '0;
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].due == cyc) begin
                ev[sb[k].lane] = 1'b1;
                ed[sb[k].lane*DW +: DW] = sb[k].d;
                sb.delete(k);
            end
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("lane%0d_valid", i), 64'(valid_out[i]), 64'(ev[i]));
            chk($sformatf("lane%0d_data", i), 64'(data_out[i*DW +: DW]), 64'(ed[i*DW +: DW]));
        end
        if (vld && e_rdy && !rs)
            for (int i = 0; i < N; i++)
                sb.push_back('{due: cyc + 1 + i, lane: i, d: d[i*DW +: DW]});
        @(posedge clk);
        #1;
        if (rs) sb.delete();
        cyc++;
    endtask

    initial begin
        tbl[0]  = mk(1, 64'hFE80_0300_0200_0100, 1, 0,  1, 0, 0, 0);
        tbl[1]  = mk(0, 64'h0, 0, 0,                     0, 1, 0, 0);
        tbl[2]  = mk(0, 64'h0, 0, 0,                     0, 1, 0, 0);
        tbl[3]  = mk(0, 64'h0, 0, 0,                     0, 1, 0, 0);
        tbl[4]  = mk(0, 64'h0, 0, 0,                     0, 1, 1, 0);
        tbl[5]  = mk(1, 64'h8000_7FFF_FFFF_0001, 0, 0,  1, 0, 0, 0);
        tbl[6]  = mk(1, 64'h1234_ABCD_0080_FF00, 0, 0,  1, 1, 0, 0);
        tbl[7]  = mk(1, 64'h0001_8001_C000_3FFF, 1, 0,  1, 1, 0, 0);
        tbl[8]  = mk(0, 64'h0, 0, 0,                     0, 1, 0, 0);
        tbl[9]  = mk(1, 64'hDEAD_BEEF_CAFE_F00D, 1, 1,  0, 1, 0, 0);
        tbl[10] = mk(0, 64'h0, 0, 0,                     0, 1, 0, 0);
        tbl[11] = mk(0, 64'h0, 0, 0,                     0, 1, 1, 0);
        tbl[12] = mk(1, 64'h0A0A_F5F5_0101_FEFE, 0, 1,  1, 0, 0, 0);
        tbl[13] = mk(0, 64'h5555_5555_5555_5555, 0, 1,  1, 1, 0, 1);
        tbl[14] = mk(1, 64'h7F00_0180_80FF_00FF, 1, 0,  1, 1, 0, 0);
        tbl[15] = mk(0, 64'h0, 0, 0,                     0, 1, 0, 0);
        tbl[16] = mk(0, 64'h0, 0, 0,                     0, 1, 0, 0);
        tbl[17] = mk(0, 64'h0, 0, 0,                     0, 1, 0, 0);
        tbl[18] = mk(0, 64'h0, 0, 0,                     0, 1, 1, 0);
        tbl[19] = mk(0, 64'h0, 0, 0,                     1, 0, 0, 0);

        // Two reset cycles; the second is checked for reset values.
        @(posedge clk);
        #1;
        step(0, '0, 0, 0, 1,  1, 0, 0, 0);

        for (int r = 0; r < 20; r++)
            step(tbl[r].vld, tbl[r].d, tbl[r].last, tbl[r].sw, 1'b0,
                 tbl[r].e_rdy, tbl[r].e_busy, tbl[r].e_done, tbl[r].e_sw);

        // Reset in the middle of DRAIN with valid held high: nothing extra accepted, no done.
        step(1, 64'hC3C3_3C3C_A5A5_5A5A, 1, 0, 0,  1, 0, 0, 0);
        step(1, 64'h1111_2222_3333_4444, 0, 0, 0,  0, 1, 0, 0);
        step(1, 64'h1111_2222_3333_4444, 0, 0, 1,  0, 1, 0, 0);
        step(0, '0, 0, 0, 0,  1, 0, 0, 0);
        step(0, '0, 0, 0, 0,  1, 0, 0, 0);
        step(0, '0, 0, 0, 0,  1, 0, 0, 0);

        // Recovery after reset: a single-vector tile behaves normally.
        step(1, 64'h8001_0002_FFFE_7FFE, 1, 1, 0,  1, 0, 0, 0);
        step(0, '0, 0, 0, 0,  0, 1, 0, 1);
        step(0, '0, 0, 0, 0,  0, 1, 0, 0);
        step(0, '0, 0, 0, 0,  0, 1, 0, 0);
        step(0, '0, 0, 0, 0,  0, 1, 1, 0);
        step(0, '0, 0, 0, 0,  1, 0, 0, 0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
